// File: rtl/output_cdf_fetch_ctrl.sv
// Round-robin arbiter and sequencer for the single CDF-memory read port shared by two pixel lanes.
// Aligns the fetch-stage StartIn and lane tag with ReadBus data, and counts pixels per frame.
module output_cdf_fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  num_pix,
  input  logic              down_ready,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fetch_start,
  output logic              tag_out,
  output logic              tag_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              rr_q, rr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_tag_q, rd_tag_d;
  logic [RD_LAT-1:0] lat_vld_q, lat_vld_d;
  logic [RD_LAT-1:0] lat_tag_q, lat_tag_d;
  logic              tag_valid_q, tag_valid_d;
  logic              tag_out_q, tag_out_d;
  logic              can_grant;
  logic              grant;
  logic              pipes_empty;

  // rr_q names the lane that wins when both lanes request in the same cycle.
  assign can_grant   = (state_q == ST_RUN) && down_ready && (remaining_q != '0);
  assign gnt0        = can_grant && req0 && (!req1 || !rr_q);
  assign gnt1        = can_grant && req1 && (!req0 || rr_q);
  assign grant       = gnt0 || gnt1;
  assign pipes_empty = !rd_en_q && (lat_vld_q == '0) && !tag_valid_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rr_d        = rr_q;
    rd_en_d     = grant;
    rd_addr_d   = rd_addr_q;
    rd_tag_d    = gnt1;
    lat_vld_d   = lat_vld_q;
    lat_tag_d   = lat_tag_q;
    tag_valid_d = lat_vld_q[RD_LAT-1];
    tag_out_d   = lat_tag_q[RD_LAT-1];

    if (grant) begin
      remaining_d = remaining_q - CNT_W'(1);
      rr_d        = gnt0;
      rd_addr_d   = gnt1 ? addr1 : addr0;
    end

    // Delay line covering the memory latency; its last stage is the StartIn strobe.
    lat_vld_d[0] = rd_en_q;
    lat_tag_d[0] = rd_tag_q;
    for (int i = 1; i < RD_LAT; i++) begin
      lat_vld_d[i] = lat_vld_q[i-1];
      lat_tag_d[i] = lat_tag_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          if (num_pix != '0) begin
            state_d     = ST_RUN;
            remaining_d = num_pix;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (grant && (remaining_q == CNT_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipes_empty) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      rr_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_tag_q    <= 1'b0;
      lat_vld_q   <= '0;
      lat_tag_q   <= '0;
      tag_valid_q <= 1'b0;
      tag_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rr_q        <= rr_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_tag_q    <= rd_tag_d;
      lat_vld_q   <= lat_vld_d;
      lat_tag_q   <= lat_tag_d;
      tag_valid_q <= tag_valid_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign fetch_start = lat_vld_q[RD_LAT-1];
  assign tag_valid   = tag_valid_q;
  assign tag_out     = tag_out_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_cdf_fetch_ctrl.sv
// Bench for output_cdf_fetch_ctrl: instances with RD_LAT=1 and RD_LAT=3 share stimulus and
// are compared every cycle against a grant-history reference model plus a vector table.
module tb_output_cdf_fetch_ctrl;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 20;

  logic              clock;
  logic              reset_n;
  logic              frame_start;
  logic [CNT_W-1:0]  num_pix;
  logic              down_ready;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;

  logic              gnt0_o[2];
  logic              gnt1_o[2];
  logic              rd_en_o[2];
  logic [ADDR_W-1:0] rd_addr_o[2];
  logic              fetch_start_o[2];
  logic              tag_out_o[2];
  logic              tag_valid_o[2];
  logic              busy_o[2];
  logic              frame_done_o[2];

  output_cdf_fetch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(1)) u_dut_lat1 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .num_pix(num_pix),
    .down_ready(down_ready), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .rd_en(rd_en_o[0]), .rd_addr(rd_addr_o[0]),
    .fetch_start(fetch_start_o[0]), .tag_out(tag_out_o[0]), .tag_valid(tag_valid_o[0]),
    .busy(busy_o[0]), .frame_done(frame_done_o[0])
  );

  output_cdf_fetch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(3)) u_dut_lat3 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .num_pix(num_pix),
    .down_ready(down_ready), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .rd_en(rd_en_o[1]), .rd_addr(rd_addr_o[1]),
    .fetch_start(fetch_start_o[1]), .tag_out(tag_out_o[1]), .tag_valid(tag_valid_o[1]),
    .busy(busy_o[1]), .frame_done(frame_done_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int                inst;
    int                cyc;
    bit                lane;
    logic [ADDR_W-1:0] addr;
  } grant_t;

  typedef struct {
    bit                fs;
    int                np;
    bit                r0;
    logic [ADDR_W-1:0] a0;
    bit                g0;
    bit                rd;
    logic [ADDR_W-1:0] addr;
    bit                fst;
    bit                tv;
    bit                tag;
    bit                busy;
    bit                done;
  } vec_t;

  int     total;
  int     bad;
  int     cyc;
  int     lat[2];
  bit     m_run[2];
  int     m_rem[2];
  bit     m_rr[2];
  int     m_done_at[2];
  grant_t hist[$];
  int     mgrants;
  bit     last_g0;
  bit     last_g1;

  int     obs_gnt[2];
  int     obs_rd[2];
  int     obs_fs[2];
  int     obs_tv[2];
  int     obs_done[2];
  bit     obs_lanes[$];
  int     g_cyc1;
  int     fs_cyc1;
  int     tv_cyc1;

  logic              snap_gnt0, snap_rd, snap_fs, snap_tv, snap_tag, snap_busy, snap_done;
  logic [ADDR_W-1:0] snap_addr;

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic int grantIdx(input int k, input int c);
    int idx;
    idx = -1;
    foreach (hist[i]) begin
      if (hist[i].inst == k && hist[i].cyc == c) idx = i;
    end
    return idx;
  endfunction

  // Arbitration rule: a lone requester wins, contention goes to the lane holding priority.
  function automatic void modelGrant(input int k, output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_run[k] && down_ready && m_rem[k] > 0) begin
      if (req0 && req1) begin
        if (m_rr[k]) g1 = 1'b1;
        else         g0 = 1'b1;
      end else if (req0) begin
        g0 = 1'b1;
      end else if (req1) begin
        g1 = 1'b1;
      end
    end
  endfunction

  task automatic checkModel(input int k);
    bit g0, g1;
    int i_rd, i_fs, i_tv;
    bit exp_busy;
    if (!reset_n) begin
      checkOutput("rst_gnt0", k, 32'(gnt0_o[k]), 0);
      checkOutput("rst_gnt1", k, 32'(gnt1_o[k]), 0);
      checkOutput("rst_rd_en", k, 32'(rd_en_o[k]), 0);
      checkOutput("rst_rd_addr", k, 32'(rd_addr_o[k]), 0);
      checkOutput("rst_fetch_start", k, 32'(fetch_start_o[k]), 0);
      checkOutput("rst_tag_out", k, 32'(tag_out_o[k]), 0);
      checkOutput("rst_tag_valid", k, 32'(tag_valid_o[k]), 0);
      checkOutput("rst_busy", k, 32'(busy_o[k]), 0);
      checkOutput("rst_frame_done", k, 32'(frame_done_o[k]), 0);
      return;
    end
    modelGrant(k, g0, g1);
    i_rd = grantIdx(k, cyc - 1);
    i_fs = grantIdx(k, cyc - 1 - lat[k]);
    i_tv = grantIdx(k, cyc - 2 - lat[k]);
    exp_busy = m_run[k] || (m_done_at[k] >= 0 && cyc < m_done_at[k]);
    checkOutput("gnt0", k, 32'(gnt0_o[k]), 32'(g0));
    checkOutput("gnt1", k, 32'(gnt1_o[k]), 32'(g1));
    checkOutput("rd_en", k, 32'(rd_en_o[k]), 32'(i_rd >= 0));
    if (i_rd >= 0) checkOutput("rd_addr", k, 32'(rd_addr_o[k]), 32'(hist[i_rd].addr));
    checkOutput("fetch_start", k, 32'(fetch_start_o[k]), 32'(i_fs >= 0));
    checkOutput("tag_valid", k, 32'(tag_valid_o[k]), 32'(i_tv >= 0));
    if (i_tv >= 0) checkOutput("tag_out", k, 32'(tag_out_o[k]), 32'(hist[i_tv].lane));
    checkOutput("busy", k, 32'(busy_o[k]), 32'(exp_busy));
    checkOutput("frame_done", k, 32'(frame_done_o[k]), 32'(cyc == m_done_at[k]));
  endtask

  task automatic modelStep(input int k);
    bit     g0, g1, idle;
    grant_t keep[$];
    foreach (hist[i]) begin
      if (hist[i].cyc > cyc - 12 && (reset_n || hist[i].inst != k)) keep.push_back(hist[i]);
    end
    hist = keep;
    if (!reset_n) begin
      m_run[k]     = 1'b0;
      m_rem[k]     = 0;
      m_rr[k]      = 1'b0;
      m_done_at[k] = -1;
      return;
    end
    modelGrant(k, g0, g1);
    idle = !m_run[k] && m_done_at[k] < 0;
    if (k == 0) begin
      last_g0 = g0;
      last_g1 = g1;
    end
    if (g0 || g1) begin
      hist.push_back('{k, cyc, g1, g1 ? addr1 : addr0});
      if (k == 0) mgrants++;
      m_rem[k]--;
      m_rr[k] = g0;
      if (m_rem[k] == 0) begin
        m_run[k]     = 1'b0;
        m_done_at[k] = cyc + 4 + lat[k];
      end
    end
    if (m_done_at[k] == cyc) m_done_at[k] = -1;
    if (idle && frame_start) begin
      if (num_pix != '0) begin
        m_run[k] = 1'b1;
        m_rem[k] = int'(num_pix);
      end else begin
        m_done_at[k] = cyc + 1;
      end
    end
  endtask

  task automatic clearObs();
    for (int k = 0; k < 2; k++) begin
      obs_gnt[k]  = 0;
      obs_rd[k]   = 0;
      obs_fs[k]   = 0;
      obs_tv[k]   = 0;
      obs_done[k] = 0;
    end
    obs_lanes.delete();
    g_cyc1  = -100;
    fs_cyc1 = -100;
    tv_cyc1 = -100;
  endtask

  task automatic applyStimulus(input bit rn, input bit fs, input int np, input bit dr,
                               input bit r0, input logic [ADDR_W-1:0] a0,
                               input bit r1, input logic [ADDR_W-1:0] a1);
    reset_n     = rn;
    frame_start = fs;
    num_pix     = CNT_W'(np);
    down_ready  = dr;
    req0        = r0;
    addr0       = a0;
    req1        = r1;
    addr1       = a1;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checkModel(k);
      if (gnt0_o[k] || gnt1_o[k]) obs_gnt[k]++;
      if (rd_en_o[k])       obs_rd[k]++;
      if (fetch_start_o[k]) obs_fs[k]++;
      if (tag_valid_o[k])   obs_tv[k]++;
      if (frame_done_o[k])  obs_done[k]++;
    end
    if (gnt0_o[0] || gnt1_o[0]) obs_lanes.push_back(gnt1_o[0]);
    if (gnt0_o[1] || gnt1_o[1]) g_cyc1 = cyc;
    if (fetch_start_o[1]) fs_cyc1 = cyc;
    if (tag_valid_o[1])   tv_cyc1 = cyc;
    snap_gnt0 = gnt0_o[0];
    snap_rd   = rd_en_o[0];
    snap_addr = rd_addr_o[0];
    snap_fs   = fetch_start_o[0];
    snap_tv   = tag_valid_o[0];
    snap_tag  = tag_out_o[0];
    snap_busy = busy_o[0];
    snap_done = frame_done_o[0];
    @(posedge clock);
    modelStep(0);
    modelStep(1);
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!(!m_run[0] && m_done_at[0] < 0 && !m_run[1] && m_done_at[1] < 0) && n < budget) begin
      applyStimulus(1, 0, 0, 1, 0, 8'h00, 0, 8'h00);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("[TB] FAIL wait_idle cyc=%0d got=timeout want=idle within %0d", cyc, budget);
    end
    idleCycles(1);
  endtask

  // Lanes hold their requests while the frame runs and step their address after each grant.
  task automatic driveFrame(input int np, input bit u0, input bit u1, input int bp_after,
                            input int extra_fs_at, input int rst_after);
    logic [ADDR_W-1:0] a0, a1;
    int low, i;
    bit dr, rn, fs;
    a0 = 8'h10;
    a1 = 8'h80;
    low = 0;
    i = 0;
    mgrants = 0;
    applyStimulus(1, 1, np, 1, u0, a0, u1, a1);
    while (m_run[0] && i < 200) begin
      dr = 1'b1;
      rn = 1'b1;
      fs = (i == extra_fs_at);
      if (bp_after >= 0 && mgrants == bp_after && low < 2) begin
        dr = 1'b0;
        low++;
      end
      if (rst_after >= 0 && mgrants == rst_after) rn = 1'b0;
      applyStimulus(rn, fs, fs ? 9 : 0, dr, u0, a0, u1, a1);
      if (!rn) clearObs();
      if (last_g0) a0++;
      if (last_g1) a1++;
      i++;
    end
    waitIdle(40);
  endtask

  initial begin
    vec_t tbl[10];
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat[0] = 1;
    lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_run[k]     = 1'b0;
      m_rem[k]     = 0;
      m_rr[k]      = 1'b0;
      m_done_at[k] = -1;
    end
    mgrants = 0;
    last_g0 = 1'b0;
    last_g1 = 1'b0;
    clearObs();
    reset_n = 1'b0; frame_start = 1'b0; num_pix = '0; down_ready = 1'b1;
    req0 = 1'b0; addr0 = '0; req1 = 1'b0; addr1 = '0;

    tbl[0] = '{1, 3, 1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 8'h10, 1, 0, 8'h00, 0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 8'h11, 1, 1, 8'h10, 0, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 1, 8'h12, 1, 1, 8'h11, 1, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 0, 8'h00, 0, 1, 8'h12, 1, 1, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    tbl[8] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0};

    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 8'h00, 0, 8'h00);

    $display("[TB] single lane vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, tbl[i].fs, tbl[i].np, 1, tbl[i].r0, tbl[i].a0, 0, 8'h00);
      checkOutput("tbl_gnt0", i, 32'(snap_gnt0), 32'(tbl[i].g0));
      checkOutput("tbl_rd_en", i, 32'(snap_rd), 32'(tbl[i].rd));
      if (tbl[i].rd) checkOutput("tbl_rd_addr", i, 32'(snap_addr), 32'(tbl[i].addr));
      checkOutput("tbl_fetch_start", i, 32'(snap_fs), 32'(tbl[i].fst));
      checkOutput("tbl_tag_valid", i, 32'(snap_tv), 32'(tbl[i].tv));
      if (tbl[i].tv) checkOutput("tbl_tag_out", i, 32'(snap_tag), 32'(tbl[i].tag));
      checkOutput("tbl_busy", i, 32'(snap_busy), 32'(tbl[i].busy));
      checkOutput("tbl_frame_done", i, 32'(snap_done), 32'(tbl[i].done));
    end

    $display("[TB] zero pixel frame");
    clearObs();
    driveFrame(0, 1, 1, -1, -1, -1);
    checkOutput("zero_gnt_count", 0, obs_gnt[0], 0);
    checkOutput("zero_rd_count", 0, obs_rd[0], 0);
    checkOutput("zero_done_count", 0, obs_done[0], 1);

    $display("[TB] backpressure");
    clearObs();
    driveFrame(4, 1, 0, 2, -1, -1);
    checkOutput("bp_gnt_count", 0, obs_gnt[0], 4);
    checkOutput("bp_fs_count", 0, obs_fs[0], 4);
    checkOutput("bp_done_count", 0, obs_done[0], 1);

    $display("[TB] frame_start ignored while running");
    clearObs();
    driveFrame(3, 1, 1, -1, 1, -1);
    checkOutput("restart_gnt_count", 0, obs_gnt[0], 3);
    checkOutput("restart_done_count", 1, obs_done[1], 1);

    $display("[TB] reset mid-frame");
    driveFrame(5, 0, 1, -1, -1, 2);
    idleCycles(6);
    checkOutput("rst_no_fetch_start", 0, obs_fs[0] + obs_fs[1], 0);
    checkOutput("rst_no_tag_valid", 0, obs_tv[0] + obs_tv[1], 0);
    clearObs();
    driveFrame(2, 1, 1, -1, -1, -1);
    checkOutput("post_rst_gnt_count", 0, obs_lanes.size(), 2);
    for (int i = 0; i < obs_lanes.size() && i < 2; i++)
      checkOutput("post_rst_lane", i, 32'(obs_lanes[i]), i % 2);

    $display("[TB] contention");
    clearObs();
    driveFrame(4, 1, 1, -1, -1, -1);
    checkOutput("cont_gnt_count", 0, obs_lanes.size(), 4);
    for (int i = 0; i < obs_lanes.size() && i < 4; i++)
      checkOutput("cont_lane", i, 32'(obs_lanes[i]), i % 2);

    $display("[TB] latency 3 single grant");
    clearObs();
    driveFrame(1, 1, 0, -1, -1, -1);
    checkOutput("lat3_fetch_delay", 1, fs_cyc1 - g_cyc1, 4);
    checkOutput("lat3_tag_delay", 1, tv_cyc1 - g_cyc1, 5);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      int np, i;
      np = (f == 3) ? 0 : int'($urandom_range(1, 12));
      i = 0;
      applyStimulus(1, 1, np, 1, 0, 8'h00, 0, 8'h00);
      while (m_run[0] && i < 300) begin
        bit xfs;
        xfs = ($urandom % 10) == 0;
        applyStimulus(1, xfs, int'($urandom_range(0, 20)), ($urandom % 4) != 0,
                      1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        i++;
      end
      waitIdle(40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
